// File: rtl/gppcu_wb_arbiter_if.sv
// Completion and writeback bundle for the GPPCU writeback arbiter.
// The slave modport is the arbiter side; the master modport is the side that feeds and observes it.
interface gppcu_wb_arbiter_if #(
    parameter int NUMREG = 32,
    parameter int DW     = 32
);
    localparam int ABW = (NUMREG > 1) ? $clog2(NUMREG) : 1;

    logic           iE_VALID;
    logic           oE_READY;
    logic [ABW-1:0] iE_REG;
    logic [DW-1:0]  iE_DATA;

    logic           iL_VALID;
    logic           oL_READY;
    logic [ABW-1:0] iL_REG;
    logic [DW-1:0]  iL_DATA;

    logic [ABW-1:0] oWRREG;
    logic           oWRREG_VALID;
    logic [DW-1:0]  oWRDATA;
    logic           oBUSY;

    modport slave (
        input  iE_VALID, iE_REG, iE_DATA,
        input  iL_VALID, iL_REG, iL_DATA,
        output oE_READY, oL_READY,
        output oWRREG, oWRREG_VALID, oWRDATA, oBUSY
    );

    modport master (
        output iE_VALID, iE_REG, iE_DATA,
        output iL_VALID, iL_REG, iL_DATA,
        input  oE_READY, oL_READY,
        input  oWRREG, oWRREG_VALID, oWRDATA, oBUSY
    );
endinterface

// File: rtl/gppcu_wb_arbiter.sv
// Buffers execute (E) and load (L) completions in two FIFOs and retires one per cycle
// onto the register-file write port using round-robin arbitration on tie.
module gppcu_wb_arbiter #(
    parameter int NUMREG = 32,
    parameter int DW     = 32,
    parameter int DEPTH  = 4
) (
    input  logic                  iACLK,
    input  logic                  iRST,
    gppcu_wb_arbiter_if.slave     bus
);
    localparam int ABW = (NUMREG > 1) ? $clog2(NUMREG) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int EW  = ABW + DW;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

    logic [EW-1:0]  r_e_mem [DEPTH];
    logic [PW-1:0]  r_e_wp;
    logic [PW-1:0]  r_e_rp;
    logic [CW-1:0]  r_e_cnt;
    logic           r_e_ready;

    logic [EW-1:0]  r_l_mem [DEPTH];
    logic [PW-1:0]  r_l_wp;
    logic [PW-1:0]  r_l_rp;
    logic [CW-1:0]  r_l_cnt;
    logic           r_l_ready;

    logic           r_prefer_l;
    logic [ABW-1:0] r_wrreg;
    logic [DW-1:0]  r_wrdata;
    logic           r_wrvalid;
    logic           r_busy;

    logic           w_e_push;
    logic           w_l_push;
    logic           w_e_ne;
    logic           w_l_ne;
    logic           w_grant_e;
    logic           w_grant_l;
    logic [CW-1:0]  w_e_cnt_nxt;
    logic [CW-1:0]  w_l_cnt_nxt;
    logic [EW-1:0]  w_e_head;
    logic [EW-1:0]  w_l_head;
    logic [EW-1:0]  w_wr_nxt;
    logic           w_wrvalid_nxt;
    logic           w_busy_nxt;
    logic           w_prefer_l_nxt;

    // Ready is a registered copy of "not full", so pushes never depend on the pop.
    assign w_e_push = bus.iE_VALID & r_e_ready;
    assign w_l_push = bus.iL_VALID & r_l_ready;
    assign w_e_ne   = (r_e_cnt != CNT_ZERO);
    assign w_l_ne   = (r_l_cnt != CNT_ZERO);
    assign w_e_head = r_e_mem[r_e_rp];
    assign w_l_head = r_l_mem[r_l_rp];

    // Grant selection from registered occupancy only; tie goes to the source not granted last.
    always_comb begin
        w_grant_e = 1'b0;
        w_grant_l = 1'b0;
        case ({w_e_ne, w_l_ne})
            2'b10: begin
                w_grant_e = 1'b1;
            end
            2'b01: begin
                w_grant_l = 1'b1;
            end
            2'b11: begin
                if (r_prefer_l) begin
                    w_grant_l = 1'b1;
                end else begin
                    w_grant_e = 1'b1;
                end
            end
            default: begin
                w_grant_e = 1'b0;
                w_grant_l = 1'b0;
            end
        endcase
    end

    // Next occupancy of the E FIFO.
    always_comb begin
        w_e_cnt_nxt = r_e_cnt;
        case ({w_e_push, w_grant_e})
            2'b10:   w_e_cnt_nxt = r_e_cnt + CNT_ONE;
            2'b01:   w_e_cnt_nxt = r_e_cnt - CNT_ONE;
            default: w_e_cnt_nxt = r_e_cnt;
        endcase
    end

    // Next occupancy of the L FIFO.
    always_comb begin
        w_l_cnt_nxt = r_l_cnt;
        case ({w_l_push, w_grant_l})
            2'b10:   w_l_cnt_nxt = r_l_cnt + CNT_ONE;
            2'b01:   w_l_cnt_nxt = r_l_cnt - CNT_ONE;
            default: w_l_cnt_nxt = r_l_cnt;
        endcase
    end

    // Next output word, strobe, busy flag and round-robin preference.
    always_comb begin
        w_wr_nxt       = {r_wrreg, r_wrdata};
        w_prefer_l_nxt = r_prefer_l;
        if (w_grant_e) begin
            w_wr_nxt       = w_e_head;
            w_prefer_l_nxt = 1'b1;
        end else if (w_grant_l) begin
            w_wr_nxt       = w_l_head;
            w_prefer_l_nxt = 1'b0;
        end else begin
            w_wr_nxt       = {r_wrreg, r_wrdata};
            w_prefer_l_nxt = r_prefer_l;
        end
        w_wrvalid_nxt = w_grant_e | w_grant_l;
        w_busy_nxt    = (w_e_cnt_nxt != CNT_ZERO) | (w_l_cnt_nxt != CNT_ZERO) | w_wrvalid_nxt;
    end

    // E FIFO storage, pointers, count and ready.
    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_e_mem[i] <= {EW{1'b0}};
            end
            r_e_wp    <= PTR_ZERO;
            r_e_rp    <= PTR_ZERO;
            r_e_cnt   <= CNT_ZERO;
            r_e_ready <= 1'b1;
        end else begin
            if (w_e_push) begin
                r_e_mem[r_e_wp] <= {bus.iE_REG, bus.iE_DATA};
                r_e_wp          <= r_e_wp + PTR_ONE;
            end
            if (w_grant_e) begin
                r_e_rp <= r_e_rp + PTR_ONE;
            end
            r_e_cnt   <= w_e_cnt_nxt;
            r_e_ready <= (w_e_cnt_nxt != FULL_CNT);
        end
    end

    // L FIFO storage, pointers, count and ready.
    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_l_mem[i] <= {EW{1'b0}};
            end
            r_l_wp    <= PTR_ZERO;
            r_l_rp    <= PTR_ZERO;
            r_l_cnt   <= CNT_ZERO;
            r_l_ready <= 1'b1;
        end else begin
            if (w_l_push) begin
                r_l_mem[r_l_wp] <= {bus.iL_REG, bus.iL_DATA};
                r_l_wp          <= r_l_wp + PTR_ONE;
            end
            if (w_grant_l) begin
                r_l_rp <= r_l_rp + PTR_ONE;
            end
            r_l_cnt   <= w_l_cnt_nxt;
            r_l_ready <= (w_l_cnt_nxt != FULL_CNT);
        end
    end

    // Write port, busy flag and arbitration history.
    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) begin
            r_wrreg    <= {ABW{1'b0}};
            r_wrdata   <= {DW{1'b0}};
            r_wrvalid  <= 1'b0;
            r_busy     <= 1'b0;
            r_prefer_l <= 1'b0;
        end else begin
            {r_wrreg, r_wrdata} <= w_wr_nxt;
            r_wrvalid  <= w_wrvalid_nxt;
            r_busy     <= w_busy_nxt;
            r_prefer_l <= w_prefer_l_nxt;
        end
    end

    assign bus.oE_READY     = r_e_ready;
    assign bus.oL_READY     = r_l_ready;
    assign bus.oWRREG       = r_wrreg;
    assign bus.oWRDATA      = r_wrdata;
    assign bus.oWRREG_VALID = r_wrvalid;
    assign bus.oBUSY        = r_busy;
endmodule

// File: tb/tb_gppcu_wb_arbiter.sv
// Scoreboard bench for gppcu_wb_arbiter: directed stimulus queues hand-ordered expected writes,
// a negedge monitor pops and compares every write strobe.
module tb_gppcu_wb_arbiter;
    localparam int NUMREG = 32;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    ent_t exp_q[$];
    ent_t m_e;

    bit rdy_e_tab [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bit rdy_l_tab [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    gppcu_wb_arbiter_if #(.NUMREG(NUMREG), .DW(DW)) bus ();

    gppcu_wb_arbiter #(.NUMREG(NUMREG), .DW(DW), .DEPTH(DEPTH)) dut (
        .iACLK (clk),
        .iRST  (rst),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        ent_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_e(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.iE_VALID = v;
        bus.iE_REG   = r;
        bus.iE_DATA  = d;
    endtask

    task automatic drive_l(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.iL_VALID = v;
        bus.iL_REG   = r;
        bus.iL_DATA  = d;
    endtask

    // Called at posedge+1; raises reset mid-cycle, checks outputs clear at once, releases later.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        exp_q.delete();
        drive_e(1'b0, 5'd0, 32'd0);
        drive_l(1'b0, 5'd0, 32'd0);
        #1;
        chk("rst_valid", 64'(bus.oWRREG_VALID), 64'd0);
        chk("rst_busy",  64'(bus.oBUSY), 64'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_e_ready", 64'(bus.oE_READY), 64'd1);
        chk("rst_l_ready", 64'(bus.oL_READY), 64'd1);
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || bus.oBUSY !== 1'b0) && c < 64) begin
            step();
            c++;
        end
        chk({name, "_drain_queue"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_drain_busy"}, 64'(bus.oBUSY), 64'd0);
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && bus.oWRREG_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: actual reg=%0d data=%0h required no write",
                         bus.oWRREG, bus.oWRDATA);
            end else begin
                m_e = exp_q.pop_front();
                chk("wr_reg",  64'(bus.oWRREG),  64'(m_e.r));
                chk("wr_data", 64'(bus.oWRDATA), 64'(m_e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ei;
        int li;
        drive_e(1'b0, 5'd0, 32'd0);
        drive_l(1'b0, 5'd0, 32'd0);
        do_reset();
        chk("rst_reg",  64'(bus.oWRREG),  64'd0);
        chk("rst_data", 64'(bus.oWRDATA), 64'd0);

        // Single write: two-cycle latency, one-cycle strobe, busy falls after edge 2.
        drive_e(1'b1, 5'd5, 32'hDEADBEEF);
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        drive_e(1'b0, 5'd0, 32'd0);
        chk("sw_valid_e0", 64'(bus.oWRREG_VALID), 64'd0);
        chk("sw_busy_e0",  64'(bus.oBUSY), 64'd1);
        step();
        chk("sw_valid_e1", 64'(bus.oWRREG_VALID), 64'd1);
        step();
        chk("sw_valid_e2", 64'(bus.oWRREG_VALID), 64'd0);
        chk("sw_busy_e2",  64'(bus.oBUSY), 64'd0);
        wait_drain("single");

        // Round-robin from reset: expected order 1,10,2,11,3 back to back.
        do_reset();
        expect_wr(5'd1,  32'h0000_1001);
        expect_wr(5'd10, 32'h0000_200A);
        expect_wr(5'd2,  32'h0000_1002);
        expect_wr(5'd11, 32'h0000_200B);
        expect_wr(5'd3,  32'h0000_1003);
        drive_e(1'b1, 5'd1, 32'h0000_1001);
        drive_l(1'b1, 5'd10, 32'h0000_200A);
        step();
        drive_e(1'b1, 5'd2, 32'h0000_1002);
        drive_l(1'b1, 5'd11, 32'h0000_200B);
        step();
        chk("rr_valid_0", 64'(bus.oWRREG_VALID), 64'd1);
        drive_e(1'b1, 5'd3, 32'h0000_1003);
        drive_l(1'b0, 5'd0, 32'd0);
        step();
        chk("rr_valid_1", 64'(bus.oWRREG_VALID), 64'd1);
        drive_e(1'b0, 5'd0, 32'd0);
        for (int k = 2; k < 5; k++) begin
            step();
            chk($sformatf("rr_valid_%0d", k), 64'(bus.oWRREG_VALID), 64'd1);
        end
        step();
        chk("rr_valid_end", 64'(bus.oWRREG_VALID), 64'd0);
        wait_drain("rr");

        // Full/backpressure: both sources held valid; ready pattern and strict alternation hand-derived.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            expect_wr(5'(k),      32'hE000_0000 + 32'(k));
            expect_wr(5'(16 + k), 32'hA000_0000 + 32'(k));
        end
        ei = 0;
        li = 0;
        for (int n = 0; n < 9; n++) begin
            chk($sformatf("full_rdy_e_%0d", n), 64'(bus.oE_READY), 64'(rdy_e_tab[n]));
            chk($sformatf("full_rdy_l_%0d", n), 64'(bus.oL_READY), 64'(rdy_l_tab[n]));
            if (n < 8) begin
                drive_e(1'b1, 5'(ei), 32'hE000_0000 + 32'(ei));
                drive_l(1'b1, 5'(16 + li), 32'hA000_0000 + 32'(li));
            end else begin
                drive_e(1'b0, 5'd0, 32'd0);
                drive_l(1'b0, 5'd0, 32'd0);
            end
            step();
            if (n < 8 && rdy_e_tab[n]) ei++;
            if (n < 8 && rdy_l_tab[n]) li++;
        end
        wait_drain("full");

        // Pointer wrap: ten E entries with irregular gaps.
        for (int i = 0; i < 10; i++) begin
            drive_e(1'b1, 5'(i), 32'h5A00_0000 + 32'(i));
            expect_wr(5'(i), 32'h5A00_0000 + 32'(i));
            step();
            drive_e(1'b0, 5'd0, 32'd0);
            for (int g = 0; g < (i % 3); g++) begin
                step();
            end
        end
        wait_drain("wrap");

        // Reset mid-operation with three entries buffered, then a fresh write of reg 31.
        drive_e(1'b1, 5'd3, 32'hC0DE_0003);
        drive_l(1'b1, 5'd4, 32'hC0DE_0004);
        step();
        drive_e(1'b1, 5'd6, 32'hC0DE_0006);
        drive_l(1'b1, 5'd8, 32'hC0DE_0008);
        step();
        do_reset();
        chk("mid_busy", 64'(bus.oBUSY), 64'd0);
        step();
        chk("mid_valid_idle", 64'(bus.oWRREG_VALID), 64'd0);
        drive_e(1'b1, 5'd31, 32'h1234_5678);
        expect_wr(5'd31, 32'h1234_5678);
        step();
        drive_e(1'b0, 5'd0, 32'd0);
        chk("mid_valid_e0", 64'(bus.oWRREG_VALID), 64'd0);
        step();
        chk("mid_valid_e1", 64'(bus.oWRREG_VALID), 64'd1);
        step();
        chk("mid_valid_e2", 64'(bus.oWRREG_VALID), 64'd0);
        wait_drain("mid");

        // Same index from both sources: last grant was E, so L wins this tie.
        expect_wr(5'd7, 32'hBBBB_0007);
        expect_wr(5'd7, 32'hAAAA_0007);
        drive_e(1'b1, 5'd7, 32'hAAAA_0007);
        drive_l(1'b1, 5'd7, 32'hBBBB_0007);
        step();
        drive_e(1'b0, 5'd0, 32'd0);
        drive_l(1'b0, 5'd0, 32'd0);
        wait_drain("same");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
